// File: rtl/amber48_uart_tx.sv
// Purpose: buffers MMIO UART byte strobes in a small FIFO and shifts them out as 8N1 frames on one pin.
// Latency: a byte pushed into an empty, idle transmitter starts its start bit two cycles later; frames are 10*CLKS_PER_BIT cycles.
// Backpressure: none towards dmem; a push into a full FIFO with no same-cycle pop is dropped and flagged in overflow_o.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   tx_valid_i     one-cycle push strobe, tx_data_i sampled with it
//   tx_data_i      byte to transmit
//   clr_overflow_i clears the sticky overflow flag (a same-cycle drop wins)
//   uart_tx_o      registered serial line, idle high
//   busy_o         frame on the line or bytes still queued
//   fifo_full_o    FIFO holds FIFO_DEPTH entries
//   fifo_level_o   current FIFO entry count
//   overflow_o     sticky, a push was dropped
module amber48_uart_tx #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             tx_valid_i,
    input  logic [7:0]                       tx_data_i,
    input  logic                             clr_overflow_i,
    output logic                             uart_tx_o,
    output logic                             busy_o,
    output logic                             fifo_full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             overflow_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("amber48_uart_tx: CLK_HZ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("amber48_uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO: circular buffer, pointers wrap naturally (power-of-two
    // depth), occupancy kept in its own counter so full/empty are trivial.
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             overflow_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_vld;
    logic             pop_vld;
    logic             drop_vld;
    logic [7:0]       head_dat;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign head_dat   = fifo_mem[rd_ptr_q];

    // A full FIFO still accepts a byte when the transmitter pops in the
    // same cycle, so the slot freed by the pop is reused immediately.
    assign push_vld = tx_valid_i & (~fifo_full | pop_vld);
    assign drop_vld = tx_valid_i & ~push_vld;

    always_comb begin : level_next
        level_d = level_q;
        case ({push_vld, pop_vld})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            fifo_mem[wr_ptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_vld) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_vld) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_vld) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM. The line value is computed for the next cycle and then
    // registered, so uart_tx_o comes straight from a flop.
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_q;
    logic             tx_d;
    logic             busy_q;
    logic             busy_d;
    logic             baud_done;

    assign baud_done = (baud_cnt_q == CNT_LAST);

    always_comb begin : fsm_next
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop_vld    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    pop_vld = 1'b1;
                    shift_d = head_dat;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = ST_DATA;
                    tx_d       = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next data bit is the one that lands in shift[0].
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop_vld = 1'b1;
                        shift_d = head_dat;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

    // busy is registered from next-state values so it tracks state_q/level_q exactly.
    assign busy_d = (state_d != ST_IDLE) | (level_d != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign uart_tx_o    = tx_q;
    assign busy_o       = busy_q;
    assign fifo_full_o  = fifo_full;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Purpose: randomized self-checking bench for amber48_uart_tx against a frame-timeline reference model.
// Latency: model predicts each frame start as pop cycle + 1, frames back to back every 100 cycles.
// Backpressure: none; the model drops pushes into a full queue unless a pop happens that cycle.
module tb_amber48_uart_tx;

    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 16;

    logic       clk_i          = 1'b0;
    logic       rst_ni         = 1'b0;
    logic       tx_valid_i     = 1'b0;
    logic [7:0] tx_data_i      = 8'h00;
    logic       clr_overflow_i = 1'b0;
    logic       uart_tx_o;
    logic       busy_o;
    logic       fifo_full_o;
    logic [4:0] fifo_level_o;
    logic       overflow_o;

    always #5 clk_i = ~clk_i;

    amber48_uart_tx #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .clr_overflow_i (clr_overflow_i),
        .uart_tx_o      (uart_tx_o),
        .busy_o         (busy_o),
        .fifo_full_o    (fifo_full_o),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queued bytes, start cycle and byte of every frame,
    // the bytes the receiver should decode, and the sticky overflow flag.
    logic [7:0] mq[$];
    int         fs[$];
    logic [7:0] fb[$];
    logic [7:0] exp_rx[$];
    int         next_pop = 0;
    logic       m_ovf    = 1'b0;
    int         cyc      = 0;
    int         epoch    = 0;
    int         peak     = 0;

    function automatic logic exp_line(input int c);
        logic r;
        r = 1'b1;
        foreach (fs[i]) begin
            int o;
            o = c - fs[i];
            if (o >= 0 && o < FRAME) begin
                if (o < CPB)          r = 1'b0;
                else if (o < 9 * CPB) r = fb[i][(o - CPB) / CPB];
                else                  r = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic frame_active(input int c);
        logic a;
        a = 1'b0;
        foreach (fs[i]) begin
            if (c >= fs[i] && c < fs[i] + FRAME) a = 1'b1;
        end
        return a;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
        int   lvl;
        logic pop;
        logic acc;
        @(posedge clk_i);
        #1;
        cyc++;
        check_val("line",  uart_tx_o,    exp_line(cyc));
        check_val("busy",  busy_o,       (mq.size() != 0) || frame_active(cyc));
        check_val("level", fifo_level_o, mq.size());
        check_val("full",  fifo_full_o,  mq.size() == DEPTH);
        check_val("ovf",   overflow_o,   m_ovf);
        if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);

        tx_valid_i     = v;
        tx_data_i      = d;
        clr_overflow_i = clr;

        lvl = mq.size();
        pop = (lvl > 0) && (cyc >= next_pop);
        if (pop) begin
            fs.push_back(cyc + 1);
            fb.push_back(mq[0]);
            exp_rx.push_back(mq[0]);
            void'(mq.pop_front());
            next_pop = cyc + FRAME;
        end
        acc = v && ((lvl < DEPTH) || pop);
        if (acc) mq.push_back(d);
        if (v && !acc)  m_ovf = 1'b1;
        else if (clr)   m_ovf = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            if (mq.size() == 0 && !frame_active(cyc + 1) && !frame_active(cyc)) done = 1'b1;
            else cycle(1'b0, 8'h00, 1'b0);
        end
        check_val("idle_timeout", done, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #3;
        rst_ni         = 1'b0;
        tx_valid_i     = 1'b0;
        clr_overflow_i = 1'b0;
        #1;
        check_val("rst_line",  uart_tx_o,    1'b1);
        check_val("rst_busy",  busy_o,       1'b0);
        check_val("rst_level", fifo_level_o, 5'd0);
        check_val("rst_ovf",   overflow_o,   1'b0);
        check_val("rst_full",  fifo_full_o,  1'b0);
        epoch++;
        // The aborted frame will never be decoded.
        if (fs.size() > 0 && fs[$] + 95 > cyc && exp_rx.size() > 0) void'(exp_rx.pop_back());
        mq.delete();
        fs.delete();
        fb.delete();
        m_ovf    = 1'b0;
        next_pop = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_hold_line",  uart_tx_o,    1'b1);
        check_val("rst_hold_level", fifo_level_o, 5'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Receiver: mid-bit sampling of each frame; frames cut by a reset are discarded.
    initial begin : rx_mon
        int         ep;
        logic [7:0] b;
        logic       ok;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && uart_tx_o === 1'b0) begin
                ep = epoch;
                ok = 1'b1;
                b  = 8'h00;
                repeat (5) @(posedge clk_i);
                #1;
                if (uart_tx_o !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(posedge clk_i);
                    #1;
                    b[k] = uart_tx_o;
                end
                repeat (CPB) @(posedge clk_i);
                #1;
                if (uart_tx_o !== 1'b1) ok = 1'b0;
                if (ep == epoch) begin
                    check_val("rx_frame", ok, 1'b1);
                    check_val("rx_queued", exp_rx.size() != 0, 1'b1);
                    if (exp_rx.size() != 0) check_val("rx_byte", b, exp_rx.pop_front());
                end
            end
        end
    end

    initial begin : main
        int c0;
        int burst;

        // Power-on reset values.
        #12;
        check_val("por_line",  uart_tx_o,    1'b1);
        check_val("por_busy",  busy_o,       1'b0);
        check_val("por_level", fifo_level_o, 5'd0);
        check_val("por_ovf",   overflow_o,   1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Single byte: exact start and busy timing.
        cycle(1'b1, 8'hA5, 1'b0);
        c0 = cyc;
        while (cyc < c0 + 110) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (cyc == c0 + 1)   check_val("a5_pre_start", uart_tx_o, 1'b1);
            if (cyc == c0 + 2)   check_val("a5_start",     uart_tx_o, 1'b0);
            if (cyc == c0 + 101) check_val("a5_busy_hi",   busy_o,    1'b1);
            if (cyc == c0 + 102) check_val("a5_busy_lo",   busy_o,    1'b0);
        end

        // Back-to-back frames.
        peak = 0;
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        wait_idle(1000);
        check_val("b2b_peak", peak, 2);

        // Overflow: 18 consecutive pushes from idle.
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_val("ovf_full",  fifo_full_o,  1'b1);
        check_val("ovf_set",   overflow_o,   1'b1);
        check_val("ovf_level", fifo_level_o, 5'd16);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check_val("ovf_clr", overflow_o, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check_val("ovf_set_wins", overflow_o, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        wait_idle(4000);

        // Random traffic with occasional bursts and clears.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic v;
            if (burst == 0 && $urandom_range(0, 499) == 0) burst = $urandom_range(5, 20);
            v = (burst > 0) || ($urandom_range(0, 59) == 0);
            if (burst > 0) burst--;
            cycle(v, 8'($urandom), $urandom_range(0, 39) == 0);
        end
        wait_idle(4000);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Reset during DATA bit 3 with five bytes queued.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0);
        c0 = cyc - 5;
        while (cyc < c0 + 2 + 43) cycle(1'b0, 8'h00, 1'b0);
        do_reset();
        repeat (300) cycle(1'b0, 8'h00, 1'b0);
        check_val("post_rst_level", fifo_level_o, 5'd0);
        check_val("post_rst_line",  uart_tx_o,    1'b1);

        // Transmitter still works after the abort.
        cycle(1'b1, 8'h96, 1'b0);
        wait_idle(1000);
        check_val("rx_left", exp_rx.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/amber48_uart_tx.md
Name: amber48_uart_tx

Overview:
- Serial transmitter downstream of the data-memory MMIO UART port.
- Consumes the one-cycle byte strobe (valid + 8-bit data) emitted on a store to the UART TX register and buffers bytes in a small FIFO.
- Shifts bytes out as 8N1 frames on a single TX pin.
- Instantiated in the board top between the dmem UART outputs and the FPGA pin; status outputs are returned to dmem for an MMIO status register.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ / BAUD (integer division, truncating); 234 at defaults.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.
- Elaboration error if CLKS_PER_BIT < 2 or FIFO_DEPTH is not a power of two.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- tx_valid_i  in  1  one-cycle push strobe from dmem; no back-pressure path exists
- tx_data_i  in  8  byte to send, sampled when tx_valid_i=1
- clr_overflow_i  in  1  clears overflow_o
- uart_tx_o  out  1  serial line, idle high
- busy_o  out  1  1 while a frame is on the line or the FIFO is non-empty
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH entries
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  current entry count
- overflow_o  out  1  sticky; a push was dropped

Behaviour:
- Reset (async assert, sync release handled upstream): uart_tx_o=1, busy_o=0, fifo_full_o=0, fifo_level_o=0, overflow_o=0, FSM=IDLE, pointers/counters=0.
- Reset asserted mid-frame aborts immediately: line returns high, FIFO contents are discarded.
- FIFO: circular buffer with write and read pointers of width log2(FIFO_DEPTH); count register is separate.
- Push happens when tx_valid_i=1 and (level < FIFO_DEPTH, or a pop occurs in the same cycle).
- Push when full with no same-cycle pop: byte dropped, overflow_o set next cycle, level unchanged.
- Simultaneous push and pop: level unchanged, both take effect.
- overflow_o clears on clr_overflow_i=1. If set and clear coincide, set wins.
- FSM states: IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1; bit index counts 0..7.
- IDLE: uart_tx_o=1. If FIFO non-empty: pop head into shift register, go START, clear baud counter.
- START: uart_tx_o=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
- DATA: uart_tx_o=shift[0] (LSB first). Each bit is held CLKS_PER_BIT cycles, then shift right and increment index. After bit 7, go STOP.
- STOP: uart_tx_o=1 for CLKS_PER_BIT cycles.
  - At the terminal count, if FIFO non-empty: pop and go directly to START (no idle gap between frames).
  - Otherwise go IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: with FIFO empty and FSM IDLE, tx_valid_i high in cycle 0 gives uart_tx_o=0 starting in cycle 2.
- uart_tx_o is driven from a flop (glitch-free).
- busy_o = (state != IDLE) | (level != 0), registered consistent with the state/level flops.
- tx_data_i is ignored when tx_valid_i=0.

Test Plan:
- Sim with CLK_HZ=1000, BAUD=100 (10 clk/bit) for all tests.
- Reset values: assert rst_ni=0 asynchronously mid-cycle -> uart_tx_o=1, busy_o=0, fifo_level_o=0, overflow_o=0 without waiting for a clock edge.
- Single byte: push 0xA5 in cycle 0 -> uart_tx_o low in cycles 2-11, then bits 1,0,1,0,0,1,0,1 (10 cycles each), then high 10 cycles. busy_o falls at cycle 102; the receiver model decodes 0xA5.
- Back-to-back: push 0x00, 0xFF, 0x55 in consecutive cycles -> fifo_level_o peaks at 2. Three contiguous 100-cycle frames with no idle gap; decoded 0x00, 0xFF, 0x55 in order.
- Overflow: with DEPTH=16, push 18 bytes in consecutive cycles starting from idle -> the first pops, 16 are buffered, one is dropped. fifo_full_o=1, overflow_o=1. The decoded stream is bytes 0..16; byte 17 is absent.
- Overflow clear: pulse clr_overflow_i -> overflow_o=0 next cycle. Pulse clr_overflow_i in the same cycle as an overflowing push -> overflow_o stays 1.
- Reset mid-frame: assert rst_ni during DATA bit 3 with 5 bytes queued -> line high immediately. After release: idle line, level 0, no further frames.
